// File: rtl/dco_coarse_tuner.sv
// Coarse-tune SAR controller for a DCO. It counts DCO cycles per reference period and
// binary-searches the 7-bit thermometer index whose frequency is nearest target*f_ref from above.
module dco_coarse_tuner #(
    parameter int CNT_W       = 10,
    parameter int SETTLE_REFS = 2,
    parameter bit POL         = 1'b0
) (
    input  logic             dco_out,
    input  logic             reset_,
    input  logic             ref_in,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    output logic [127:0]     coarse,
    output logic [6:0]       code,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             busy,
    output logic             done,
    output logic             sat
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_MEAS   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_REFS);

    // Thermometer expansion: bits [idx-1:0] set, the rest clear.
    function automatic logic [127:0] therm_of(input logic [6:0] idx);
        logic [127:0] t;
        t = 128'd0;
        for (int i = 0; i < 128; i++) begin
            t[i] = (8'(i) < {1'b0, idx});
        end
        return t;
    endfunction

    logic [2:0]       state_r;
    logic             sync1_r;
    logic             sync2_r;
    logic             sync3_r;
    logic [CNT_W-1:0] target_r;
    logic [2:0]       bit_r;
    logic [6:0]       idx_r;
    logic [3:0]       settle_r;
    logic [CNT_W-1:0] cyc_cnt_r;
    logic [CNT_W-1:0] meas_cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             sat_r;
    logic [127:0]     coarse_r;

    logic             ref_tick_s;
    logic [CNT_W-1:0] cyc_inc_s;
    logic             keep_s;
    logic [6:0]       idx_trial_s;

    // Reference synchroniser plus edge-detect stage.
    always_ff @(posedge dco_out or negedge reset_) begin
        if (!reset_) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
        end else begin
            sync1_r <= ref_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    assign ref_tick_s = sync2_r & ~sync3_r;

    // Saturating cycle count including the current cycle, and the trial-bit decision.
    always_comb begin
        if (cyc_cnt_r == CNT_MAX) begin
            cyc_inc_s = CNT_MAX;
        end else begin
            cyc_inc_s = cyc_cnt_r + CNT_ONE;
        end
        // A saturated count is always treated as "DCO too fast".
        if (POL) begin
            keep_s = (cyc_inc_s < target_r) && (cyc_inc_s != CNT_MAX);
        end else begin
            keep_s = (cyc_inc_s >= target_r) || (cyc_inc_s == CNT_MAX);
        end
    end

    // Next SAR index: resolve the trial bit and, if any remain, raise the next lower one.
    always_comb begin
        idx_trial_s        = idx_r;
        idx_trial_s[bit_r] = keep_s;
        if (bit_r != 3'd0) begin
            idx_trial_s[bit_r - 3'd1] = 1'b1;
        end else begin
            idx_trial_s = idx_trial_s;
        end
    end

    // Search sequencer: align to ref, settle after each code change, measure, evaluate.
    always_ff @(posedge dco_out or negedge reset_) begin
        if (!reset_) begin
            state_r    <= ST_IDLE;
            target_r   <= {CNT_W{1'b0}};
            bit_r      <= 3'd0;
            idx_r      <= 7'd0;
            settle_r   <= 4'd0;
            cyc_cnt_r  <= {CNT_W{1'b0}};
            meas_cnt_r <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sat_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        target_r <= target;
                        bit_r    <= 3'd6;
                        idx_r    <= 7'b1000000;
                        sat_r    <= 1'b0;
                        busy_r   <= 1'b1;
                        state_r  <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (ref_tick_s) begin
                        settle_r <= SETTLE_LOAD;
                        state_r  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (ref_tick_s) begin
                        if (settle_r <= 4'd1) begin
                            settle_r  <= 4'd0;
                            cyc_cnt_r <= {CNT_W{1'b0}};
                            state_r   <= ST_MEAS;
                        end else begin
                            settle_r <= settle_r - 4'd1;
                        end
                    end
                end
                ST_MEAS: begin
                    cyc_cnt_r <= cyc_inc_s;
                    if (cyc_inc_s == CNT_MAX) begin
                        sat_r <= 1'b1;
                    end
                    if (ref_tick_s) begin
                        meas_cnt_r <= cyc_inc_s;
                        idx_r      <= idx_trial_s;
                        if (bit_r != 3'd0) begin
                            bit_r    <= bit_r - 3'd1;
                            settle_r <= SETTLE_LOAD;
                            state_r  <= ST_SETTLE;
                        end else begin
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Coarse word trails the index by one cycle so it only moves after start or an evaluation.
    always_ff @(posedge dco_out or negedge reset_) begin
        if (!reset_) begin
            coarse_r <= 128'd0;
        end else begin
            coarse_r <= therm_of(idx_r);
        end
    end

    assign coarse   = coarse_r;
    assign code     = idx_r;
    assign meas_cnt = meas_cnt_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sat      = sat_r;

endmodule

// File: tb/tb_dco_coarse_tuner.sv
// Directed bench for dco_coarse_tuner: a behavioural DCO whose frequency is 1 GHz - 5 MHz*ones(coarse)
// closes the loop, and a gated reference clock drives the searches.
`timescale 1ns/1ps
module tb_dco_coarse_tuner;

    logic         dco_out;
    logic         reset_;
    logic         ref_in;
    logic         start;
    logic [9:0]   target;
    logic [127:0] coarse;
    logic [6:0]   code;
    logic [9:0]   meas_cnt;
    logic         busy;
    logic         done;
    logic         sat;

    int  checks = 0;
    int  errors = 0;
    int  ref_edges = 0;
    int  done_cnt = 0;
    real ref_half = 50.0;
    bit  ref_en = 1'b1;
    bit  log_en = 1'b0;
    bit  chk_coarse = 1'b0;
    logic [6:0] prev_code = 7'd0;
    logic [6:0] trial_q[$];

    dco_coarse_tuner dut (
        .dco_out  (dco_out),
        .reset_   (reset_),
        .ref_in   (ref_in),
        .start    (start),
        .target   (target),
        .coarse   (coarse),
        .code     (code),
        .meas_cnt (meas_cnt),
        .busy     (busy),
        .done     (done),
        .sat      (sat)
    );

    function automatic logic [127:0] therm_f(input int n);
        logic [127:0] ones;
        ones = '1;
        if (n <= 0) return 128'd0;
        return ones >> (128 - n);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural DCO: half period follows the number of ones on the coarse word.
    initial begin
        real hp;
        dco_out = 1'b0;
        forever begin
            hp = 500.0 / (1000.0 - 5.0 * $countones(coarse));
            #(hp) dco_out = ~dco_out;
        end
    end

    initial begin
        ref_in = 1'b0;
        forever begin
            #(ref_half);
            if (ref_en) ref_in = ~ref_in;
            else        ref_in = 1'b0;
        end
    end

    always @(posedge ref_in) ref_edges++;

    always @(negedge dco_out) if (done === 1'b1) done_cnt++;

    // Trial log: every code change during a logged search, with the coarse word checked a cycle later.
    always @(negedge dco_out) begin
        if (chk_coarse) begin
            check("trial_coarse_therm", coarse, therm_f(int'(code)));
            chk_coarse = 1'b0;
        end
        if (log_en && code !== prev_code) begin
            trial_q.push_back(code);
            chk_coarse = 1'b1;
        end
        prev_code = code;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input logic [9:0] t);
        @(negedge dco_out);
        start  = 1'b1;
        target = t;
        @(negedge dco_out);
        start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            @(negedge dco_out);
            n++;
        end
        check({tag, "_done_seen"}, {127'd0, done}, 128'd1);
    endtask

    initial begin
        int e0;
        int n;
        int d0;
        logic [6:0] exp_trials [8];
        exp_trials = '{7'd64, 7'd32, 7'd48, 7'd40, 7'd44, 7'd42, 7'd41, 7'd40};

        reset_ = 1'b0;
        start  = 1'b0;
        target = 10'd0;
        #20;
        check("rst_coarse", coarse, 128'd0);
        check("rst_code", code, 128'd0);
        check("rst_meas", meas_cnt, 128'd0);
        check("rst_busy", busy, 128'd0);
        check("rst_done", done, 128'd0);
        check("rst_sat", sat, 128'd0);
        @(negedge dco_out);
        reset_ = 1'b1;

        // target=0: every trial is "too fast", so all bits are kept; stray starts must not re-latch.
        d0 = done_cnt;
        pulse_start(10'd0);
        check("t0_busy", busy, 128'd1);
        check("t0_code_start", code, 128'd64);
        @(negedge dco_out);
        check("t0_coarse_start", coarse, therm_f(64));
        pulse_start(10'd1023);
        check("t0_stray1_busy", busy, 128'd1);
        repeat (495) @(negedge dco_out);
        pulse_start(10'd1023);
        check("t0_stray2_busy", busy, 128'd1);
        wait_done(20000, "t0");
        check("t0_busy_at_done", busy, 128'd0);
        check("t0_code", code, 128'd127);
        start  = 1'b1;
        target = 10'd5;
        @(negedge dco_out);
        start = 1'b0;
        check("t0_finish_start_ignored", busy, 128'd0);
        check("t0_done_width", done, 128'd0);
        check("t0_coarse", coarse, therm_f(127));
        repeat (3) @(negedge dco_out);
        check("t0_done_once", done_cnt, d0 + 1);
        check("t0_sat", sat, 128'd0);

        // target=1023: no unsaturated count reaches it, so every bit is cleared.
        pulse_start(10'd1023);
        wait_done(20000, "t1023");
        check("t1023_code", code, 128'd0);
        @(negedge dco_out);
        check("t1023_coarse", coarse, 128'd0);
        check("t1023_meas_range", {127'd0, (meas_cnt >= 10'd98 && meas_cnt <= 10'd101)}, 128'd1);

        // Linear model with a 1 MHz ref: count = 1000-5*idx; threshold 798 lies between idx 40 and 41.
        ref_half = 500.0;
        repeat (2) @(posedge ref_in);
        trial_q.delete();
        log_en = 1'b1;
        e0 = ref_edges;
        pulse_start(10'd798);
        wait_done(60000, "lin");
        repeat (3) @(negedge dco_out);
        log_en = 1'b0;
        check("lin_code", code, 128'd40);
        check("lin_coarse", coarse, therm_f(40));
        check("lin_ones", $countones(coarse), 128'd40);
        check("lin_ref_periods", {127'd0, ((ref_edges - e0) >= 21 && (ref_edges - e0) <= 23)}, 128'd1);
        check("lin_meas_range", {127'd0, (meas_cnt >= 10'd794 && meas_cnt <= 10'd796)}, 128'd1);
        check("lin_trial_count", trial_q.size(), 128'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < trial_q.size()) check($sformatf("lin_trial_%0d", i), trial_q[i], exp_trials[i]);
            else check($sformatf("lin_trial_%0d_missing", i), 128'd0, exp_trials[i]);
        end

        // Reset mid-search drops everything asynchronously; a start afterwards is accepted.
        ref_half = 50.0;
        pulse_start(10'd798);
        repeat (400) @(negedge dco_out);
        #0.2;
        reset_ = 1'b0;
        #1;
        check("mid_rst_coarse", coarse, 128'd0);
        check("mid_rst_code", code, 128'd0);
        check("mid_rst_busy", busy, 128'd0);
        #14;
        reset_ = 1'b1;
        pulse_start(10'd0);
        check("post_rst_busy", busy, 128'd1);
        check("post_rst_code", code, 128'd64);
        wait_done(20000, "post_rst");
        check("post_rst_final", code, 128'd127);

        // Stalled reference in MEAS: count saturates, busy holds, coarse does not move.
        pulse_start(10'd1023);
        n = 0;
        while (code === 7'd64 && n < 5000) begin
            @(negedge dco_out);
            n++;
        end
        check("stall_first_eval", code, 128'd32);
        @(posedge ref_in);
        @(posedge ref_in);
        ref_en = 1'b0;
        repeat (900) @(negedge dco_out);
        check("stall_sat_early", sat, 128'd0);
        repeat (200) @(negedge dco_out);
        check("stall_sat", sat, 128'd1);
        check("stall_busy", busy, 128'd1);
        check("stall_code", code, 128'd32);
        check("stall_coarse", coarse, therm_f(32));

        // Ref activity resumes the search; sat is sticky until the next start.
        ref_en = 1'b1;
        wait_done(20000, "resume");
        check("resume_sat_sticky", sat, 128'd1);
        pulse_start(10'd0);
        check("start_clears_sat", sat, 128'd0);
        wait_done(20000, "last");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
